// File: rtl/enable_axi4_burst_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package : enable_axi_pkg
// Brief   : Shared types, response codes and burst legality check for the
//           enable AXI4 burst slave.
// Rev     : 1.0  initial release
// ============================================================================
package enable_axi_pkg;

  // AXI burst encodings; 2'b11 is reserved and treated as an error
  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // A burst is serviceable only at full bus width, with a defined burst
  // type, and for WRAP only with a power-of-two beat count of 2..16.
  function automatic logic burst_legal(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [2:0] full_size);
    logic ok;
    ok = (size == full_size) && (burst != 2'b11);
    if (burst == WRAP) begin
      ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enable_axi4_burst_slave_if.sv
`default_nettype none
// ============================================================================
// Interface : enable_axi4_burst_slave_if
// Brief     : AXI4 five-channel bundle (no cache/prot/qos/user sidebands).
// Rev       : 1.0  initial release
// ============================================================================
interface enable_axi4_burst_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 8
);
  // write address
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  // write data
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  // write response
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  // read address
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  // read data
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface
`default_nettype wire

// File: rtl/enable_axi4_burst_slave_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : enable_axi_addr_gen
// Brief  : Next word index for FIXED / INCR / WRAP bursts. INCR rolls over
//          at the top of the array; WRAP stays inside the aligned window of
//          (wrap_len+1) words.
// Rev    : 1.0  initial release
// ============================================================================
module enable_axi_addr_gen
  import enable_axi_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [3:0]       wrap_len,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next_idx
);

  logic [IDX_W-1:0] w_inc;
  logic [IDX_W-1:0] w_mask;

  // Legal WRAP lengths are 2^n-1, so the length doubles as the window mask
  always_comb begin
    w_inc    = cur_idx + 1'b1;
    w_mask   = IDX_W'(wrap_len);
    next_idx = w_inc;
    case (burst)
      FIXED:   next_idx = cur_idx;
      WRAP:    next_idx = (cur_idx & ~w_mask) | (w_inc & w_mask);
      default: next_idx = w_inc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/enable_axi4_burst_slave.sv
`default_nettype none
// ============================================================================
// Module : enable_axi4_burst_slave
// Brief  : AXI4 burst slave over a DEPTH x DATA_WIDTH register array. Bits
//          NUM_CH-1:0 of word 0 drive the enable outputs, optionally as
//          self-clearing pulses.
// Rev    : 1.0  initial release
// ============================================================================
module enable_axi4_burst_slave
  import enable_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH * DATA_WIDTH / 8),
  parameter int NUM_CH     = 8,
  parameter int EN_PULSE   = 0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  enable_axi4_burst_slave_if.slave   axi,
  output logic [NUM_CH-1:0]          en_o
);

  localparam int         BYTES     = DATA_WIDTH / 8;
  localparam int         BYTE_SH   = $clog2(BYTES);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(BYTE_SH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write --
  wr_state_t           r_wstate;
  wr_state_t           w_wstate_nxt;
  logic [ID_WIDTH-1:0] r_wid;
  logic [IDX_W-1:0]    r_widx;
  logic [IDX_W-1:0]    w_widx_nxt;
  logic [7:0]          r_wlen;
  logic [1:0]          r_wburst;
  logic                r_werr;
  logic [7:0]          r_wcnt;
  logic [1:0]          r_bresp;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_w_final;
  logic                w_mem_we;

  assign w_aw_hs   = (r_wstate == W_IDLE) && axi.AWVALID;
  assign w_w_hs    = (r_wstate == W_DATA) && axi.WVALID;
  assign w_w_final = w_w_hs && (axi.WLAST || (r_wcnt == r_wlen));
  assign w_mem_we  = w_w_hs && !r_werr;

  enable_axi_addr_gen #(.IDX_W(IDX_W)) u_wr_addr (
    .cur_idx  (r_widx),
    .wrap_len (r_wlen[3:0]),
    .burst    (r_wburst),
    .next_idx (w_widx_nxt)
  );

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state and channel handshake outputs
  always_comb begin
    w_wstate_nxt = r_wstate;
    axi.AWREADY  = 1'b0;
    axi.WREADY   = 1'b0;
    axi.BVALID   = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        axi.AWREADY = 1'b1;
        if (axi.AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        axi.WREADY = 1'b1;
        if (w_w_final) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        axi.BVALID = 1'b1;
        if (axi.BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write command capture, beat address/count, and response code
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wburst <= 2'b01;
      r_werr   <= 1'b0;
      r_wcnt   <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_wid    <= axi.AWID;
        r_widx   <= axi.AWADDR[BYTE_SH +: IDX_W];
        r_wlen   <= axi.AWLEN;
        r_wburst <= axi.AWBURST;
        r_werr   <= !burst_legal(axi.AWLEN, axi.AWSIZE, axi.AWBURST, FULL_SIZE);
        r_wcnt   <= '0;
      end
      if (w_w_hs) begin
        r_widx <= w_widx_nxt;
        r_wcnt <= r_wcnt + 8'd1;
      end
      // An early WLAST still closes the burst but flags it
      if (w_w_final) begin
        r_bresp <= (r_werr || (r_wcnt != r_wlen)) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axi.BID   = r_wid;
  assign axi.BRESP = r_bresp;

  // Storage: byte-lane writes; in pulse mode the enable bits of word 0 are
  // cleared every cycle unless a write sets them in that same cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (EN_PULSE != 0) mem[0][NUM_CH-1:0] <= '0;
      if (w_mem_we) begin
        for (int b = 0; b < BYTES; b++) begin
          if (axi.WSTRB[b]) mem[r_widx][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
        end
      end
    end
  end

  assign en_o = mem[0][NUM_CH-1:0];

  // ----------------------------------------------------------------- read --
  rd_state_t             r_rstate;
  rd_state_t             w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [IDX_W-1:0]      r_ridx;
  logic [IDX_W-1:0]      w_ridx_nxt;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [7:0]            r_rlen;
  logic [1:0]            r_rburst;
  logic                  r_rerr;
  logic                  w_ar_err;
  logic [7:0]            r_rcnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_r_last;

  assign w_ar_hs  = (r_rstate == R_IDLE) && axi.ARVALID;
  assign w_r_hs   = (r_rstate == R_DATA) && axi.RREADY;
  assign w_r_last = (r_rcnt == r_rlen);
  assign w_ar_idx = axi.ARADDR[BYTE_SH +: IDX_W];
  assign w_ar_err = !burst_legal(axi.ARLEN, axi.ARSIZE, axi.ARBURST, FULL_SIZE);

  enable_axi_addr_gen #(.IDX_W(IDX_W)) u_rd_addr (
    .cur_idx  (r_ridx),
    .wrap_len (r_rlen[3:0]),
    .burst    (r_rburst),
    .next_idx (w_ridx_nxt)
  );

  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and channel handshake outputs
  always_comb begin
    w_rstate_nxt = r_rstate;
    axi.ARREADY  = 1'b0;
    axi.RVALID   = 1'b0;
    axi.RLAST    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        axi.ARREADY = 1'b1;
        if (axi.ARVALID) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        axi.RVALID = 1'b1;
        axi.RLAST  = w_r_last;
        if (axi.RREADY && w_r_last) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read command capture and data prefetch; the array is sampled at the
  // clock edge so a same-cycle write to the word is not yet visible
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rburst <= 2'b01;
      r_rerr   <= 1'b0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rid    <= axi.ARID;
      r_ridx   <= w_ar_idx;
      r_rlen   <= axi.ARLEN;
      r_rburst <= axi.ARBURST;
      r_rerr   <= w_ar_err;
      r_rcnt   <= '0;
      r_rdata  <= w_ar_err ? '0 : mem[w_ar_idx];
      r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
    end else if (w_r_hs && !w_r_last) begin
      r_ridx  <= w_ridx_nxt;
      r_rcnt  <= r_rcnt + 8'd1;
      r_rdata <= r_rerr ? '0 : mem[w_ridx_nxt];
    end
  end

  assign axi.RID   = r_rid;
  assign axi.RDATA = r_rdata;
  assign axi.RRESP = r_rresp;

  // Byte-offset address bits carry no information for full-width beats
  logic w_unused;
  assign w_unused = ^{axi.AWADDR, axi.ARADDR};

endmodule
`default_nettype wire

// File: tb/tb_enable_axi4_burst_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_enable_axi4_burst_slave
// Brief  : Directed + randomized bench with a word-array reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_enable_axi4_burst_slave;

  localparam int DEPTH = 64;
  localparam int TMO   = 200;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [7:0] en;
  logic [7:0] p_en;

  always #5 ACLK = ~ACLK;

  enable_axi4_burst_slave_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(8)) axi_if ();
  enable_axi4_burst_slave_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .ADDR_WIDTH(8)) p_if ();

  enable_axi4_burst_slave #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ID_WIDTH(4),
                            .ADDR_WIDTH(8), .NUM_CH(8), .EN_PULSE(0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .axi(axi_if), .en_o(en));

  enable_axi4_burst_slave #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ID_WIDTH(4),
                            .ADDR_WIDTH(8), .NUM_CH(8), .EN_PULSE(1)) dut_pulse (
    .ACLK(ACLK), .ARESETN(ARESETN), .axi(p_if), .en_o(p_en));

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size != 3'd2 || burst == 2'd3) return 1'b0;
    if (burst == 2'd2) return (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  // Word touched by beat i of a burst
  function automatic int ref_idx(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst, input int i);
    int s, n, base;
    s = (int'(addr) / 4) % DEPTH;
    n = int'(len) + 1;
    if (burst == 2'd0) return s;
    if (burst == 2'd2) begin
      base = s - (s % n);
      return base + ((s - base + i) % n);
    end
    return (s + i) % DEPTH;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nb);
    int t;
    bit legal;
    int idx;
    logic [1:0] exp_resp;
    legal = ref_legal(len, size, burst);
    axi_if.AWID = id; axi_if.AWADDR = addr; axi_if.AWLEN = len;
    axi_if.AWSIZE = size; axi_if.AWBURST = burst; axi_if.AWVALID = 1'b1;
    t = 0;
    while (!axi_if.AWREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
    check("aw_wait", t < TMO, 1'b1);
    @(posedge ACLK); #1;
    axi_if.AWVALID = 1'b0;
    check("wready_lat", axi_if.WREADY, 1'b1);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge ACLK); #1; end
      axi_if.WDATA = wd[i]; axi_if.WSTRB = ws[i];
      axi_if.WLAST = (i == nb - 1); axi_if.WVALID = 1'b1;
      t = 0;
      while (!axi_if.WREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
      check("w_wait", t < TMO, 1'b1);
      @(posedge ACLK); #1;
      axi_if.WVALID = 1'b0;
    end
    axi_if.WLAST = 1'b0;
    check("bvalid_lat", axi_if.BVALID, 1'b1);
    if (legal) begin
      for (int i = 0; i < nb; i++) begin
        idx = ref_idx(addr, len, burst, i);
        for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    exp_resp = (legal && nb == int'(len) + 1) ? 2'b00 : 2'b10;
    repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    axi_if.BREADY = 1'b1;
    t = 0;
    while (!axi_if.BVALID && t < TMO) begin @(posedge ACLK); #1; t++; end
    check("bid", axi_if.BID, id);
    check("bresp", axi_if.BRESP, exp_resp);
    @(posedge ACLK); #1;
    axi_if.BREADY = 1'b0;
    check("en", en, ref_mem[0][7:0]);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t, beat;
    bit legal;
    legal = ref_legal(len, size, burst);
    axi_if.ARID = id; axi_if.ARADDR = addr; axi_if.ARLEN = len;
    axi_if.ARSIZE = size; axi_if.ARBURST = burst; axi_if.ARVALID = 1'b1;
    t = 0;
    while (!axi_if.ARREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
    check("ar_wait", t < TMO, 1'b1);
    @(posedge ACLK); #1;
    axi_if.ARVALID = 1'b0;
    check("rvalid_lat", axi_if.RVALID, 1'b1);
    beat = 0; t = 0;
    while (beat <= int'(len) && t < TMO) begin
      axi_if.RREADY = ($urandom_range(0, 3) != 0);
      if (axi_if.RVALID && axi_if.RREADY) begin
        if (beat < 16) rd[beat] = axi_if.RDATA;
        check("rdata", axi_if.RDATA, legal ? ref_mem[ref_idx(addr, len, burst, beat)] : 32'h0);
        check("rresp", axi_if.RRESP, legal ? 2'b00 : 2'b10);
        check("rlast", axi_if.RLAST, beat == int'(len));
        check("rid", axi_if.RID, id);
        beat++;
      end
      @(posedge ACLK); #1; t++;
    end
    axi_if.RREADY = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("r_idle", axi_if.RVALID, 1'b0);
  endtask

  initial begin
    int t, hs;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    axi_if.AWVALID = 0; axi_if.WVALID = 0; axi_if.BREADY = 0; axi_if.ARVALID = 0; axi_if.RREADY = 0;
    axi_if.AWID = 0; axi_if.AWADDR = 0; axi_if.AWLEN = 0; axi_if.AWSIZE = 0; axi_if.AWBURST = 0;
    axi_if.WDATA = 0; axi_if.WSTRB = 0; axi_if.WLAST = 0;
    axi_if.ARID = 0; axi_if.ARADDR = 0; axi_if.ARLEN = 0; axi_if.ARSIZE = 0; axi_if.ARBURST = 0;
    p_if.AWVALID = 0; p_if.WVALID = 0; p_if.BREADY = 0; p_if.ARVALID = 0; p_if.RREADY = 0;
    p_if.AWID = 0; p_if.AWADDR = 0; p_if.AWLEN = 0; p_if.AWSIZE = 3'd2; p_if.AWBURST = 2'd1;
    p_if.WDATA = 0; p_if.WSTRB = 0; p_if.WLAST = 0;
    p_if.ARID = 0; p_if.ARADDR = 0; p_if.ARLEN = 0; p_if.ARSIZE = 3'd2; p_if.ARBURST = 2'd1;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", axi_if.AWREADY, 1'b1);
    check("rst_arready", axi_if.ARREADY, 1'b1);
    check("rst_wready", axi_if.WREADY, 1'b0);
    check("rst_bvalid", axi_if.BVALID, 1'b0);
    check("rst_rvalid", axi_if.RVALID, 1'b0);
    check("rst_rlast", axi_if.RLAST, 1'b0);
    check("rst_resp", {axi_if.BRESP, axi_if.RRESP}, 4'h0);
    check("rst_ids", {axi_if.BID, axi_if.RID}, 8'h0);
    check("rst_rdata", axi_if.RDATA, 32'h0);
    check("rst_en", en, 8'h0);
    #3 ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // INCR 8-beat write/read from word 0
    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'd1, 8'h00, 8'd7, 3'd2, 2'd1, 8);
    do_read(4'd2, 8'h00, 8'd7, 3'd2, 2'd1);
    check("incr_en", en, 8'h01);
    check("incr_beat8", rd[7], 32'h8);

    // WRAP write at 0x18 then INCR read from 0x10
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
    do_write(4'd3, 8'h18, 8'd3, 3'd2, 2'd2, 4);
    do_read(4'd4, 8'h10, 8'd3, 3'd2, 2'd1);
    check("wrap_w4", rd[0], 32'hC);
    check("wrap_w5", rd[1], 32'hD);
    check("wrap_w6", rd[2], 32'hA);
    check("wrap_w7", rd[3], 32'hB);

    // byte strobes
    wd[0] = 32'h5555_5555; ws[0] = 4'hF;
    do_write(4'd5, 8'h20, 8'd0, 3'd2, 2'd1, 1);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0010;
    do_write(4'd5, 8'h20, 8'd0, 3'd2, 2'd1, 1);
    do_read(4'd5, 8'h20, 8'd0, 3'd2, 2'd1);
    check("wstrb_word", rd[0], 32'h5555_FF55);

    // bad size write; bad WRAP length read
    wd[0] = 32'hDEAD_BEEF; wd[1] = 32'hCAFE_F00D; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'd6, 8'h10, 8'd1, 3'd1, 2'd1, 2);
    do_read(4'd6, 8'h10, 8'd1, 3'd2, 2'd1);
    check("size_err_keep", rd[0], 32'hC);
    do_read(4'd7, 8'h00, 8'd2, 3'd2, 2'd2);

    // early WLAST: 2 of 4 beats, kept, SLVERR
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'd8, 8'h30, 8'd3, 3'd2, 2'd1, 2);
    do_read(4'd8, 8'h30, 8'd3, 3'd2, 2'd1);

    // pulse-mode enables
    p_if.AWADDR = 8'h00; p_if.AWLEN = 8'd0; p_if.AWVALID = 1'b1;
    check("p_awready", p_if.AWREADY, 1'b1);
    @(posedge ACLK); #1;
    p_if.AWVALID = 1'b0;
    p_if.WDATA = 32'h105; p_if.WSTRB = 4'hF; p_if.WLAST = 1'b1; p_if.WVALID = 1'b1;
    check("p_wready", p_if.WREADY, 1'b1);
    @(posedge ACLK); #1;
    p_if.WVALID = 1'b0;
    check("p_en_set", p_en, 8'h05);
    p_if.BREADY = 1'b1;
    @(posedge ACLK); #1;
    p_if.BREADY = 1'b0;
    check("p_en_clr", p_en, 8'h00);
    p_if.ARADDR = 8'h00; p_if.ARLEN = 8'd0; p_if.ARVALID = 1'b1;
    @(posedge ACLK); #1;
    p_if.ARVALID = 1'b0; p_if.RREADY = 1'b1;
    check("p_rvalid", p_if.RVALID, 1'b1);
    check("p_rdata", p_if.RDATA, 32'h100);
    @(posedge ACLK); #1;
    p_if.RREADY = 1'b0;

    // reset during beat 3 of an 8-beat read
    axi_if.ARID = 4'd9; axi_if.ARADDR = 8'h00; axi_if.ARLEN = 8'd7;
    axi_if.ARSIZE = 3'd2; axi_if.ARBURST = 2'd1; axi_if.ARVALID = 1'b1;
    @(posedge ACLK); #1;
    axi_if.ARVALID = 1'b0; axi_if.RREADY = 1'b1;
    hs = 0; t = 0;
    while (hs < 2 && t < TMO) begin
      if (axi_if.RVALID) hs++;
      @(posedge ACLK); #1; t++;
    end
    check("rst_mid_beats", hs, 2);
    check("rst_mid_rvalid_pre", axi_if.RVALID, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_mid_rvalid", axi_if.RVALID, 1'b0);
    axi_if.RREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(posedge ACLK);
    #4 ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("rst_mid_arready", axi_if.ARREADY, 1'b1);
    check("rst_mid_en", en, 8'h00);
    do_read(4'd10, 8'h00, 8'd3, 3'd2, 2'd1);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      logic [7:0] a, l;
      logic [2:0] s;
      logic [1:0] bt;
      int nb;
      a  = 8'($urandom);
      bt = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) bt = 2'd3;
      l  = 8'($urandom_range(0, 15));
      if (bt == 2'd2 && $urandom_range(0, 4) != 0) l = 8'((1 << $urandom_range(1, 4)) - 1);
      s  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        nb = int'(l) + 1;
        if (l > 0 && $urandom_range(0, 5) == 0) nb = int'($urandom_range(1, int'(l)));
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(4'($urandom), a, l, s, bt, nb);
      end else begin
        do_read(4'($urandom), a, l, s, bt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enable_axi4_burst_slave.md
# enable_axi4_burst_slave

Parametrised AXI4 full-protocol burst slave that backs a register/memory array and drives NUM_CH enable outputs from word 0. It sits behind the AXI interconnect in the block design, in the slot of the current fixed-width enable peripheral. It generalises data width, depth and channel count. It adds FIXED/INCR/WRAP burst handling, WSTRB byte lanes, SLVERR signalling and an optional self-clearing pulse mode for the enables.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- DEPTH, 64, number of DATA_WIDTH words; power of two, at least 16.
- ID_WIDTH, 4, AXI ID width, echoed on BID/RID.
- ADDR_WIDTH, clog2(DEPTH*DATA_WIDTH/8), byte address width.
- NUM_CH, 8, enable channels; at most DATA_WIDTH.
- EN_PULSE, 0, 0 = enables are level bits; 1 = enables self-clear one cycle after being written.

Ports:
- ACLK in 1 clock; all logic on the rising edge.
- ARESETN in 1 asynchronous active-low reset.
- AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]/AWVALID in; AWREADY out: write address channel.
- WDATA[DATA_WIDTH]/WSTRB[DATA_WIDTH/8]/WLAST/WVALID in; WREADY out: write data channel.
- BID[ID_WIDTH]/BRESP[2]/BVALID out; BREADY in: write response channel.
- ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]/ARVALID in; ARREADY out: read address channel.
- RID/RDATA/RRESP[2]/RLAST/RVALID out; RREADY in: read data channel.
- en_o out NUM_CH: enable outputs, equal to mem[0][NUM_CH-1:0].

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. An AW handshake latches ID, address, length, burst type and error flag, then moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the enabled WSTRB bytes to mem[addr], then advances the address. The beat with WLAST, or the beat whose count reaches AWLEN+1, moves to W_RESP.
  - W_RESP: BVALID=1 until BREADY, then W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake latches the command, moves to R_DATA and loads RDATA with mem[ARADDR].
  - R_DATA: RVALID=1. Each R handshake advances the address and reloads RDATA. RLAST=1 on beat ARLEN. The final handshake returns the FSM to R_IDLE.
- The two FSMs are independent; each allows one outstanding burst.
- Address arithmetic: word index = byte address >> clog2(DATA_WIDTH/8), taken modulo DEPTH, so it wraps at the top of the array.
  - FIXED keeps the address constant.
  - INCR adds one word per beat.
  - WRAP wraps within an aligned window of (LEN+1) words.
- Errors return SLVERR (2'b10); no memory update occurs, but every beat is still accepted or returned. An error is any of:
  - SIZE not equal to clog2(DATA_WIDTH/8);
  - burst type 2'b11;
  - WRAP with LEN not in {1,3,7,15}.
- Error reads return RDATA=0. All other responses are OKAY.
- WLAST arriving early ends the burst with SLVERR; beats already written are kept.
- A write to word 0 updates en_o the following cycle. With EN_PULSE=1, bits NUM_CH-1:0 of word 0 clear one cycle after they are set.
- Same-cycle read and write of one word: the read returns the old data.

## Timing
- Reset values:
  - AWREADY=1, ARREADY=1.
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0.
  - BRESP=0, RRESP=0, RDATA=0, BID=0, RID=0.
  - en_o=0 and the memory array cleared to 0.
- Latency:
  - AW handshake to first WREADY: 1 cycle.
  - Last W handshake to BVALID: 1 cycle.
  - AR handshake to first RVALID: 1 cycle.
  - Subsequent R beats: back-to-back while RREADY=1.
- VALID signals, once asserted, and their payloads are held stable until the handshake completes.
- Reset asserted mid-burst aborts both FSMs immediately. No response is issued for the aborted burst.

## Structure
- Package enable_axi_pkg holds:
  - the burst-type enum (FIXED, INCR, WRAP);
  - the RESP_OKAY and RESP_SLVERR constants;
  - the write and read FSM state enums;
  - a burst_legal(len, size, burst) function.
- Sub-module enable_axi_addr_gen: combinational next-word-index computation for FIXED/INCR/WRAP. It is instantiated once per FSM.

## Test plan
- INCR burst: AWADDR 0, AWLEN 7, data 1..8, WSTRB all-ones, then ARADDR 0, ARLEN 7 -> BRESP OKAY; RDATA returns 1..8 with RLAST on beat 8; en_o = 8'h01.
- WRAP burst: AWADDR 0x18, AWLEN 3, data A..D -> words 6,7,4,5 hold A,B,C,D; a 4-beat INCR read from 0x10 returns C,D,A,B.
- WSTRB 4'b0010 writing 0xFFFFFFFF over word 0x55555555 -> readback 0x5555FF55.
- AWSIZE=1 write, 2 beats -> both beats accepted, BRESP SLVERR, memory unchanged; WRAP read with ARLEN 2 -> 3 beats of RDATA 0, RRESP SLVERR.
- EN_PULSE=1, write 0x5 to word 0 -> en_o=0x5 for exactly one cycle, then 0; a read of word 0 afterwards returns 0.
- ARESETN low during beat 3 of an 8-beat read -> RVALID drops asynchronously, ARREADY=1 after release, and a new read completes normally.
